vec_alu_sched: RTL and testbench

Single-issue scheduler for the four-lane vector ALU wrapper. It accepts one vector arithmetic request at a time over a valid/ready handshake and latches the opcode, operand type and element width. It enables the requested number of lane `run` strobes, waits for the wrapper's `done_out`, and then returns to idle. It delivers a write-back token over a second valid/ready handshake, supervises each operation with a timeout, and supports synchronous flush.

---
 rtl/vec_alu_sched_if.sv | 44 ++++
 rtl/vec_alu_sched.sv | 215 +++++++++++++++++++++
 tb/tb_vec_alu_sched.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vec_alu_sched_if.sv
// vec_alu_sched_if
//   Groups the handshake and bus signals of the vector ALU scheduler:
//   request channel (req_*), ALU wrapper control (alu_*), write-back
//   channel (wb_*).
//   modport master : scheduler view (accepts requests, drives the ALU
//                    wrapper, sources write-back tokens)
//   modport slave  : environment view (request source, ALU wrapper,
//                    write-back consumer)
interface vec_alu_sched_if;
  logic       req_valid;
  logic       req_ready;
  logic [5:0] req_opcode;
  logic [2:0] req_op_type;
  logic [2:0] req_vsew;

  logic [5:0] alu_opcode;
  logic [2:0] alu_op_type;
  logic [2:0] alu_vsew;
  logic [1:0] alu_nb_lanes;
  logic       alu_run0;
  logic       alu_run1;
  logic       alu_run2;
  logic       alu_run3;
  logic       alu_done;

  logic       wb_valid;
  logic       wb_ready;
  logic [5:0] wb_opcode;
  logic       wb_err;

  modport master (
    input  req_valid, req_opcode, req_op_type, req_vsew, alu_done, wb_ready,
    output req_ready, alu_opcode, alu_op_type, alu_vsew, alu_nb_lanes,
           alu_run0, alu_run1, alu_run2, alu_run3,
           wb_valid, wb_opcode, wb_err
  );

  modport slave (
    output req_valid, req_opcode, req_op_type, req_vsew, alu_done, wb_ready,
    input  req_ready, alu_opcode, alu_op_type, alu_vsew, alu_nb_lanes,
           alu_run0, alu_run1, alu_run2, alu_run3,
           wb_valid, wb_opcode, wb_err
  );
endinterface

// File: rtl/vec_alu_sched.sv
// vec_alu_sched
//   Single-issue scheduler for the four-lane vector ALU wrapper. Accepts
//   one request, latches its fields, raises the lane run strobes until the
//   wrapper reports done (or the operation times out), then offers a
//   write-back token.
//
//   Ports:
//     clk, resetn   clock and asynchronous active-low reset
//     cfg_nb_lanes  log2 of active lanes, sampled at accept (3 clamps to 2)
//     flush         synchronous abort to IDLE, no write-back
//     err_clr       clears err_sticky (a same-cycle timeout wins)
//     err_sticky    set on any timeout
//     bus           vec_alu_sched_if.master: req_*, alu_*, wb_* signals
//
//   Optional build macro VEC_ALU_SCHED_PERF_EN adds perf_ops (write-back
//   handshakes) and perf_busy (cycles in RUN), 32-bit wrapping counters.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   S_IDLE | req_ready high, waiting for a request
//   S_RUN  | lane run strobes high, waiting for alu_done or timeout
//   S_WB   | runs low, wb_valid held until wb_ready
module vec_alu_sched #(
  parameter logic [15:0] TIMEOUT = 16'd1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [1:0]  cfg_nb_lanes,
  input  logic        flush,
  input  logic        err_clr,
  output logic        err_sticky,
`ifdef VEC_ALU_SCHED_PERF_EN
  output logic [31:0] perf_ops,
  output logic [31:0] perf_busy,
`endif
  vec_alu_sched_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [15:0] cnt;
  logic [15:0] cnt_nxt;
  logic [3:0]  run_q;
  logic [3:0]  run_nxt;
  logic        wb_valid_q;
  logic        wb_valid_nxt;
  logic        wb_err_q;
  logic        wb_err_nxt;
  logic [5:0]  wb_opcode_q;
  logic [5:0]  opcode_q;
  logic [2:0]  op_type_q;
  logic [2:0]  vsew_q;
  logic [1:0]  nb_lanes_q;
  logic [1:0]  lanes_clamped;
  logic        load_req;
  logic        wb_load;
  logic        err_set;
  logic        timeout_hit;

  function automatic logic [3:0] lane_mask(input logic [1:0] nb);
    logic [3:0] m;
    case (nb)
      2'd0:    m = 4'b0001;
      2'd1:    m = 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  assign lanes_clamped = (cfg_nb_lanes == 2'd3) ? 2'd2 : cfg_nb_lanes;
  // Counter holds the number of RUN cycles already completed, so the compare
  // against TIMEOUT-1 lets runs stay high for exactly TIMEOUT cycles.
  assign timeout_hit   = (cnt >= (TIMEOUT - 16'd1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    run_nxt      = 4'b0000;
    wb_valid_nxt = 1'b0;
    wb_err_nxt   = wb_err_q;
    load_req     = 1'b0;
    wb_load      = 1'b0;
    err_set      = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.req_valid) begin
          load_req  = 1'b1;
          cnt_nxt   = 16'd0;
          run_nxt   = lane_mask(lanes_clamped);
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        cnt_nxt = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
        if (bus.alu_done) begin
          state_nxt    = S_WB;
          wb_valid_nxt = 1'b1;
          wb_err_nxt   = 1'b0;
          wb_load      = 1'b1;
        end else if (timeout_hit) begin
          state_nxt    = S_WB;
          wb_valid_nxt = 1'b1;
          wb_err_nxt   = 1'b1;
          wb_load      = 1'b1;
          err_set      = 1'b1;
        end else begin
          run_nxt = lane_mask(nb_lanes_q);
        end
      end
      S_WB: begin
        if (bus.wb_ready) begin
          state_nxt = S_IDLE;
        end else begin
          wb_valid_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Flush overrides everything, including a same-cycle accept or timeout.
    if (flush) begin
      state_nxt    = S_IDLE;
      run_nxt      = 4'b0000;
      wb_valid_nxt = 1'b0;
      wb_err_nxt   = wb_err_q;
      load_req     = 1'b0;
      wb_load      = 1'b0;
      err_set      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt         <= 16'd0;
      run_q       <= 4'b0000;
      wb_valid_q  <= 1'b0;
      wb_err_q    <= 1'b0;
      wb_opcode_q <= 6'd0;
      opcode_q    <= 6'd0;
      op_type_q   <= 3'd0;
      vsew_q      <= 3'd0;
      nb_lanes_q  <= 2'd0;
      err_sticky  <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      run_q      <= run_nxt;
      wb_valid_q <= wb_valid_nxt;
      wb_err_q   <= wb_err_nxt;
      if (load_req) begin
        opcode_q   <= bus.req_opcode;
        op_type_q  <= bus.req_op_type;
        vsew_q     <= bus.req_vsew;
        nb_lanes_q <= lanes_clamped;
      end
      if (wb_load) begin
        wb_opcode_q <= opcode_q;
      end
      if (err_set) begin
        err_sticky <= 1'b1;
      end else if (err_clr) begin
        err_sticky <= 1'b0;
      end
    end
  end

`ifdef VEC_ALU_SCHED_PERF_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_ops  <= 32'd0;
      perf_busy <= 32'd0;
    end else begin
      if ((state == S_WB) && bus.wb_ready && !flush) begin
        perf_ops <= perf_ops + 32'd1;
      end
      if (state == S_RUN) begin
        perf_busy <= perf_busy + 32'd1;
      end
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

  assign bus.req_ready    = (state == S_IDLE) && !flush;
  assign bus.alu_opcode   = opcode_q;
  assign bus.alu_op_type  = op_type_q;
  assign bus.alu_vsew     = vsew_q;
  assign bus.alu_nb_lanes = nb_lanes_q;
  assign bus.alu_run0     = run_q[0];
  assign bus.alu_run1     = run_q[1];
  assign bus.alu_run2     = run_q[2];
  assign bus.alu_run3     = run_q[3];
  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_opcode    = wb_opcode_q;
  assign bus.wb_err       = wb_err_q;

endmodule

// File: tb/tb_vec_alu_sched.sv
module tb_vec_alu_sched;
  localparam logic [15:0] TMO = 16'd16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [1:0]  cfg_nb_lanes = 2'd0;
  logic        flush = 1'b0;
  logic        err_clr = 1'b0;
  logic        err_sticky;
`ifdef VEC_ALU_SCHED_PERF_EN
  logic [31:0] perf_ops;
  logic [31:0] perf_busy;
`endif

  vec_alu_sched_if bus();

  vec_alu_sched #(.TIMEOUT(TMO)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .cfg_nb_lanes (cfg_nb_lanes),
    .flush        (flush),
    .err_clr      (err_clr),
    .err_sticky   (err_sticky),
`ifdef VEC_ALU_SCHED_PERF_EN
    .perf_ops     (perf_ops),
    .perf_busy    (perf_busy),
`endif
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_fail = 0;
  int n_chk  = 0;
  bit sticky_m = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] runs();
    return {bus.alu_run3, bus.alu_run2, bus.alu_run1, bus.alu_run0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: run length = min(done cycle, TIMEOUT), error when done
  // comes later than TIMEOUT, lane mask = 2^(2^lanes)-1 with lanes 3 -> 2.
  task automatic run_op(input logic [5:0] opc, input logic [2:0] ot, input logic [2:0] vs,
                        input logic [1:0] nbl, input int done_at, input int wb_wait,
                        input bit hold_clr);
    int         exp_len;
    bit         exp_err;
    logic [1:0] eff;
    logic [3:0] exp_mask;
    int         run_seen;
    int         wb_cycle;
    bit         bad;
    bit         got_wb;
    bit         unstable;
    logic [5:0] wo;
    logic       we;
    exp_len  = (done_at > int'(TMO)) ? int'(TMO) : done_at;
    exp_err  = (done_at > int'(TMO));
    eff      = (nbl == 2'd3) ? 2'd2 : nbl;
    exp_mask = 4'((1 << (1 << eff)) - 1);

    check("idle_req_ready", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid   = 1'b1;
    bus.req_opcode  = opc;
    bus.req_op_type = ot;
    bus.req_vsew    = vs;
    cfg_nb_lanes    = nbl;
    step();
    bus.req_valid   = 1'b0;
    bus.req_opcode  = 6'($urandom);
    bus.req_vsew    = 3'($urandom);
    cfg_nb_lanes    = 2'($urandom);
    err_clr         = hold_clr;

    run_seen = 0;
    wb_cycle = 0;
    bad      = 1'b0;
    got_wb   = 1'b0;
    for (int k = 1; k <= int'(TMO) + 4 && !got_wb; k++) begin
      if (bus.wb_valid) begin
        got_wb   = 1'b1;
        wb_cycle = k;
      end else begin
        if (runs() == exp_mask) run_seen++;
        else bad = 1'b1;
        bus.alu_done = (k == done_at);
        step();
      end
    end
    bus.alu_done = 1'b0;
    err_clr      = 1'b0;
    if (exp_err) sticky_m = 1'b1;
    else if (hold_clr) sticky_m = 1'b0;

    check("wb_seen", {31'd0, got_wb}, 32'd1);
    check("wb_cycle", wb_cycle, exp_len + 1);
    check("run_cycles", run_seen, exp_len);
    check("run_pattern_bad", {31'd0, bad}, 32'd0);
    check("runs_low_in_wb", {28'd0, runs()}, 32'd0);
    check("alu_nb_lanes", {30'd0, bus.alu_nb_lanes}, {30'd0, eff});
    check("alu_opcode", {26'd0, bus.alu_opcode}, {26'd0, opc});
    check("alu_op_type", {29'd0, bus.alu_op_type}, {29'd0, ot});
    check("alu_vsew", {29'd0, bus.alu_vsew}, {29'd0, vs});
    check("wb_opcode", {26'd0, bus.wb_opcode}, {26'd0, opc});
    check("wb_err", {31'd0, bus.wb_err}, {31'd0, exp_err});
    check("err_sticky", {31'd0, err_sticky}, {31'd0, sticky_m});

    wo = bus.wb_opcode;
    we = bus.wb_err;
    unstable = 1'b0;
    for (int i = 0; i < wb_wait; i++) begin
      bus.alu_done = 1'($urandom_range(0, 1));
      step();
      if (!bus.wb_valid || bus.wb_opcode !== wo || bus.wb_err !== we ||
          bus.req_ready || runs() != 4'b0000)
        unstable = 1'b1;
    end
    bus.alu_done = 1'b0;
    check("wb_hold_stable", {31'd0, unstable}, 32'd0);
    bus.wb_ready = 1'b1;
    step();
    bus.wb_ready = 1'b0;
    check("wb_valid_after_hs", {31'd0, bus.wb_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid   = 1'b0;
    bus.req_opcode  = 6'd0;
    bus.req_op_type = 3'd0;
    bus.req_vsew    = 3'd0;
    bus.alu_done    = 1'b0;
    bus.wb_ready    = 1'b0;

    #12;
    check("rst_runs", {28'd0, runs()}, 32'd0);
    check("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    check("rst_wb_opcode", {26'd0, bus.wb_opcode}, 32'd0);
    check("rst_alu_opcode", {26'd0, bus.alu_opcode}, 32'd0);
    check("rst_err_sticky", {31'd0, err_sticky}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    step();
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);

    // done pulse while idle is ignored
    bus.alu_done = 1'b1;
    step();
    bus.alu_done = 1'b0;
    check("idle_done_wb", {31'd0, bus.wb_valid}, 32'd0);
    check("idle_done_runs", {28'd0, runs()}, 32'd0);

    run_op(6'h05, 3'b001, 3'd0, 2'd2, 8, 0, 1'b0);
    run_op(6'h12, 3'b010, 3'd1, 2'd0, 4, 1, 1'b0);
    run_op(6'h33, 3'b100, 3'd2, 2'd3, 6, 0, 1'b0);

    // timeout, then clear
    run_op(6'h2a, 3'b010, 3'd1, 2'd1, 40, 0, 1'b0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    sticky_m = 1'b0;
    check("err_clr", {31'd0, err_sticky}, 32'd0);

    // err_clr held during a timeout: set wins
    run_op(6'h07, 3'b001, 3'd3, 2'd2, 40, 0, 1'b1);

    // write-back stall
    run_op(6'h11, 3'b100, 3'd2, 2'd2, 5, 5, 1'b0);

    // flush at RUN cycle 3
    bus.req_valid  = 1'b1;
    bus.req_opcode = 6'h21;
    cfg_nb_lanes   = 2'd2;
    step();
    bus.req_valid  = 1'b0;
    step();
    step();
    flush = 1'b1;
    step();
    check("flush_runs", {28'd0, runs()}, 32'd0);
    check("flush_wb", {31'd0, bus.wb_valid}, 32'd0);
    flush = 1'b0;
    #1;
    check("flush_idle", {31'd0, bus.req_ready}, 32'd1);
    step();
    step();
    check("flush_no_wb", {31'd0, bus.wb_valid}, 32'd0);

    // flush coincident with a request
    bus.req_valid = 1'b1;
    flush = 1'b1;
    #1;
    check("flush_gates_ready", {31'd0, bus.req_ready}, 32'd0);
    step();
    bus.req_valid = 1'b0;
    flush = 1'b0;
    #1;
    check("coinc_runs", {28'd0, runs()}, 32'd0);
    check("coinc_idle", {31'd0, bus.req_ready}, 32'd1);
    step();
    check("coinc_no_wb", {31'd0, bus.wb_valid}, 32'd0);

    for (int r = 0; r < 12; r++) begin
      run_op(6'($urandom), 3'(1 << $urandom_range(0, 2)), 3'($urandom), 2'($urandom),
             int'($urandom_range(1, 20)), int'($urandom_range(0, 4)),
             $urandom_range(0, 3) == 0);
    end

    // reset in the middle of RUN with err_sticky set
    run_op(6'h3c, 3'b001, 3'd0, 2'd1, 40, 0, 1'b0);
    bus.req_valid  = 1'b1;
    bus.req_opcode = 6'h19;
    cfg_nb_lanes   = 2'd2;
    step();
    bus.req_valid  = 1'b0;
    step();
    step();
    check("pre_rst_runs", {28'd0, runs()}, 32'd15);
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_runs", {28'd0, runs()}, 32'd0);
    check("async_rst_wb", {31'd0, bus.wb_valid}, 32'd0);
    check("async_rst_opcode", {26'd0, bus.alu_opcode}, 32'd0);
    check("async_rst_sticky", {31'd0, err_sticky}, 32'd0);
    sticky_m = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    step();
    check("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);
`ifdef VEC_ALU_SCHED_PERF_EN
    check("perf_ops_rst", perf_ops, 32'd0);
    check("perf_busy_rst", perf_busy, 32'd0);
`endif
    for (int j = 0; j < 3; j++) begin
      run_op(6'(j + 1), 3'b001, 3'd0, 2'd2, 8, j, 1'b0);
    end
`ifdef VEC_ALU_SCHED_PERF_EN
    check("perf_ops", perf_ops, 32'd3);
    check("perf_busy", perf_busy, 32'd24);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
